// File: rtl/cpudiv_pkg.sv
// Shared CPU definitions used by the divider: ALU-compatible flag bit
// positions and the divider FSM state encoding.
package cpudiv_pkg;
  localparam int FLAG_V = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_t;
endpackage

// File: rtl/cpudiv_if.sv
// Issue/result handshake between the execute stage and the divider.
interface cpudiv_if #(parameter int BW = 32);
  logic          i_wr;
  logic          i_signed;
  logic [BW-1:0] i_numerator;
  logic [BW-1:0] i_denominator;
  logic          o_busy;
  logic          o_valid;
  logic          o_err;
  logic [BW-1:0] o_quotient;
  logic [3:0]    o_flags;

  modport master (
    output i_wr, i_signed, i_numerator, i_denominator,
    input  o_busy, o_valid, o_err, o_quotient, o_flags
  );

  modport slave (
    input  i_wr, i_signed, i_numerator, i_denominator,
    output o_busy, o_valid, o_err, o_quotient, o_flags
  );
endinterface

// File: rtl/cpudiv.sv
// Iterative restoring divider: one quotient bit per clock on operand
// magnitudes, sign applied in a final fix-up cycle; divide-by-zero short-cuts.
module cpudiv
  import cpudiv_pkg::*;
#(
  parameter int BW   = 32,
  parameter int LGBW = 5
) (
  input logic      i_clk,
  input logic      i_rst,
  cpudiv_if.slave  dif
);

  div_state_t      r_state, w_state_n;
  logic            r_busy, r_valid, r_err;
  logic            r_neg, r_ovf;
  logic [BW-1:0]   r_quot_o;
  logic [3:0]      r_flags;
  logic [LGBW-1:0] r_cnt;
  logic [BW-1:0]   r_num, r_den, r_rem, r_quot;
  logic [BW:0]     w_trial;
  logic [BW-1:0]   w_qfinal;
  logic [3:0]      w_flags, w_zflags;
  logic            w_accept;

  function automatic logic [BW-1:0] magnitude(input logic [BW-1:0] x,
                                               input logic sgn);
    return (sgn && x[BW-1]) ? (~x + 1'b1) : x;
  endfunction

  assign w_accept = dif.i_wr && (r_state == IDLE);
  // The remainder MSB is always 0 before a shift, so the full-width concat is exact.
  assign w_trial  = {r_rem, r_num[BW-1]} - {1'b0, r_den};
  assign w_qfinal = r_neg ? (~r_quot + 1'b1) : r_quot;

  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_V]  = r_ovf;
    w_flags[FLAG_N]  = w_qfinal[BW-1];
    w_flags[FLAG_Z]  = (w_qfinal == '0);
    w_zflags         = '0;
    w_zflags[FLAG_Z] = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      IDLE:      if (w_accept) w_state_n = (dif.i_denominator == '0) ? ZERO : RUN;
      RUN:       if (r_cnt == '0) w_state_n = FIX;
      FIX, ZERO: w_state_n = IDLE;
      default:   w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy   <= 1'b0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_quot_o <= '0;
      r_flags  <= '0;
      r_cnt    <= '0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_busy <= 1'b1;
          r_cnt  <= LGBW'(BW - 1);
        end
        RUN:  r_cnt <= r_cnt - 1'b1;
        FIX: begin
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_err    <= 1'b0;
          r_quot_o <= w_qfinal;
          r_flags  <= w_flags;
        end
        ZERO: begin
          r_busy   <= 1'b0;
          r_valid  <= 1'b1;
          r_err    <= 1'b1;
          r_quot_o <= '0;
          r_flags  <= w_zflags;
        end
        default: ;
      endcase
    end
  end

  // Datapath needs no reset: every division reloads it on acceptance.
  always_ff @(posedge i_clk) begin
    case (r_state)
      IDLE: if (w_accept) begin
        r_neg  <= dif.i_signed & (dif.i_numerator[BW-1] ^ dif.i_denominator[BW-1]);
        r_ovf  <= dif.i_signed && (dif.i_numerator == {1'b1, {(BW-1){1'b0}}})
                  && (dif.i_denominator == '1);
        r_num  <= magnitude(dif.i_numerator, dif.i_signed);
        r_den  <= magnitude(dif.i_denominator, dif.i_signed);
        r_rem  <= '0;
        r_quot <= '0;
      end
      RUN: begin
        if (!w_trial[BW]) begin
          r_rem  <= w_trial[BW-1:0];
          r_quot <= {r_quot[BW-2:0], 1'b1};
        end else begin
          r_rem  <= {r_rem[BW-2:0], r_num[BW-1]};
          r_quot <= {r_quot[BW-2:0], 1'b0};
        end
        r_num <= {r_num[BW-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  assign dif.o_busy     = r_busy;
  assign dif.o_valid    = r_valid;
  assign dif.o_err      = r_err;
  assign dif.o_quotient = r_quot_o;
  assign dif.o_flags    = r_flags;

endmodule

// File: tb/tb_cpudiv.sv
// Scoreboard bench for cpudiv: expected results queued at issue, popped when
// o_valid appears, compared inline by each scenario task.
module tb_cpudiv;
  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  typedef struct {
    logic [31:0] q;
    logic [3:0]  f;
    logic        e;
    int          lat;
  } exp_t;

  exp_t sb[$];

  cpudiv_if #(.BW(32)) dif ();

  cpudiv #(.BW(32), .LGBW(5)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .dif   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(input logic [31:0] n, input logic [31:0] d,
                                 input logic s);
    exp_t   r;
    longint qn;
    if (d == 32'd0) begin
      r.q = 32'd0; r.f = 4'b0001; r.e = 1'b1; r.lat = 1;
      return r;
    end
    if (s) qn = longint'($signed(n)) / longint'($signed(d));
    else   qn = longint'({32'd0, n}) / longint'({32'd0, d});
    r.q   = qn[31:0];
    r.e   = 1'b0;
    r.lat = 33;
    r.f   = {s && (n == 32'h80000000) && (d == 32'hFFFFFFFF), r.q[31], 1'b0, r.q == 32'd0};
    return r;
  endfunction

  // Pulse i_wr for one edge (E0) and queue the expected result.
  task automatic issue(input logic [31:0] n, input logic [31:0] d,
                       input logic s, input exp_t ex);
    @(negedge clk);
    dif.i_wr = 1'b1; dif.i_numerator = n; dif.i_denominator = d; dif.i_signed = s;
    sb.push_back(ex);
    @(posedge clk); #1;
    dif.i_wr = 1'b0;
  endtask

  // Bounded wait for o_valid; lat counts edges after E0.
  task automatic wait_result(output logic got, output int lat, output logic [31:0] q,
                             output logic [3:0] f, output logic e);
    got = 1'b0; lat = 0; q = 'x; f = 'x; e = 1'bx;
    for (int i = 1; i <= 40 && !got; i++) begin
      @(posedge clk); #1;
      if (dif.o_valid) begin
        got = 1'b1; lat = i; q = dif.o_quotient; f = dif.o_flags; e = dif.o_err;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.i_wr = 1'b0; dif.i_signed = 1'b0; dif.i_numerator = '0; dif.i_denominator = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", dif.o_busy); end
    n_tests++; if (dif.o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", dif.o_valid); end
    n_tests++; if (dif.o_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", dif.o_err); end
    n_tests++; if (dif.o_quotient !== 32'd0) begin n_fail++; $display("FAIL reset_quot: got %h expected 0", dif.o_quotient); end
    rst = 1'b0;
  endtask

  task automatic test_divide();
    logic [31:0] tn[9] = '{32'd100, 32'hFFFFFF9C, 32'hFFFFFFFF, 32'h80000000, 32'h80000000,
                           32'd100, 32'hFFFFFF9C, 32'd3, 32'hFFFFFFFF};
    logic [31:0] td[9] = '{32'd7, 32'd7, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFF9, 32'hFFFFFFF9, 32'd5, 32'hFFFFFFFE};
    logic        ts[9] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [31:0] tq[9] = '{32'd14, 32'hFFFFFFF2, 32'hFFFFFFFF, 32'h80000000, 32'd0,
                           32'hFFFFFFF2, 32'd14, 32'd0, 32'd1};
    logic [3:0]  tf[9] = '{4'b0000, 4'b0100, 4'b0100, 4'b1100, 4'b0001,
                           4'b0100, 4'b0000, 4'b0001, 4'b0000};
    exp_t ex; logic got; int lat; logic [31:0] q, n, d; logic [3:0] f; logic e, s;
    for (int i = 0; i < 13; i++) begin
      if (i < 9) begin
        n = tn[i]; d = td[i]; s = ts[i];
        ex.q = tq[i]; ex.f = tf[i]; ex.e = 1'b0; ex.lat = 33;
      end else begin
        n = $urandom; d = $urandom >> $urandom_range(0, 28); s = 1'($urandom_range(0, 1));
        if (d == 32'd0) d = 32'd3;
        ex = model(n, d, s);
      end
      issue(n, d, s, ex);
      wait_result(got, lat, q, f, e);
      ex = sb.pop_front();
      n_tests++; if (lat !== ex.lat) begin n_fail++; $display("FAIL div[%0d]_latency: got %0d expected %0d", i, lat, ex.lat); end
      n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL div[%0d]_quot %h/%h s=%b: got %h expected %h", i, n, d, s, q, ex.q); end
      n_tests++; if (f !== ex.f) begin n_fail++; $display("FAIL div[%0d]_flags: got %b expected %b", i, f, ex.f); end
      n_tests++; if (e !== ex.e) begin n_fail++; $display("FAIL div[%0d]_err: got %b expected %b", i, e, ex.e); end
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] zn[2] = '{32'd1234, 32'h80000000};
    logic        zs[2] = '{1'b0, 1'b1};
    exp_t ex; logic got; int lat; logic [31:0] q; logic [3:0] f; logic e;
    for (int i = 0; i < 2; i++) begin
      ex.q = 32'd0; ex.f = 4'b0001; ex.e = 1'b1; ex.lat = 1;
      issue(zn[i], 32'd0, zs[i], ex);
      wait_result(got, lat, q, f, e);
      ex = sb.pop_front();
      n_tests++; if (lat !== ex.lat) begin n_fail++; $display("FAIL dz[%0d]_latency: got %0d expected %0d", i, lat, ex.lat); end
      n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL dz[%0d]_quot: got %h expected %h", i, q, ex.q); end
      n_tests++; if (f !== ex.f) begin n_fail++; $display("FAIL dz[%0d]_flags: got %b expected %b", i, f, ex.f); end
      n_tests++; if (e !== ex.e) begin n_fail++; $display("FAIL dz[%0d]_err: got %b expected %b", i, e, ex.e); end
      n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL dz[%0d]_busy: got %b expected 0", i, dif.o_busy); end
    end
  endtask

  task automatic test_busy_ignore();
    exp_t ex; int nvalid = 0; int lat = 0; logic [31:0] q = 'x;
    logic b1 = 1'bx, b32 = 1'bx;
    ex.q = 32'd100; ex.f = 4'b0000; ex.e = 1'b0; ex.lat = 33;
    issue(32'd1000, 32'd10, 1'b0, ex);
    for (int i = 1; i <= 45; i++) begin
      dif.i_wr = (i == 5 || i == 20);
      dif.i_numerator = 32'd7; dif.i_denominator = 32'd7;
      @(posedge clk); #1;
      dif.i_wr = 1'b0;
      if (i == 1)  b1  = dif.o_busy;
      if (i == 32) b32 = dif.o_busy;
      if (dif.o_valid) begin nvalid++; lat = i; q = dif.o_quotient; end
    end
    ex = sb.pop_front();
    n_tests++; if (b1 !== 1'b1) begin n_fail++; $display("FAIL busy_at_e1: got %b expected 1", b1); end
    n_tests++; if (b32 !== 1'b1) begin n_fail++; $display("FAIL busy_at_e32: got %b expected 1", b32); end
    n_tests++; if (nvalid !== 1) begin n_fail++; $display("FAIL busy_valid_count: got %0d expected 1", nvalid); end
    n_tests++; if (lat !== ex.lat) begin n_fail++; $display("FAIL busy_latency: got %0d expected %0d", lat, ex.lat); end
    n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL busy_quot: got %h expected %h", q, ex.q); end
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL busy_idle_after: got %b expected 0", dif.o_busy); end
  endtask

  task automatic test_back_to_back();
    exp_t ex; logic got; int lat; logic [31:0] q; logic [3:0] f; logic e;
    ex.q = 32'd10; ex.f = 4'b0000; ex.e = 1'b0; ex.lat = 33;
    issue(32'd50, 32'd5, 1'b0, ex);
    wait_result(got, lat, q, f, e);
    ex = sb.pop_front();
    n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL b2b_first_quot: got %h expected %h", q, ex.q); end
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL b2b_busy_in_valid: got %b expected 0", dif.o_busy); end
    // Still inside the o_valid cycle: issue the next division now.
    dif.i_wr = 1'b1; dif.i_numerator = 32'd90; dif.i_denominator = 32'd3; dif.i_signed = 1'b0;
    ex.q = 32'd30; ex.f = 4'b0000; ex.e = 1'b0; ex.lat = 33;
    sb.push_back(ex);
    @(posedge clk); #1;
    dif.i_wr = 1'b0;
    n_tests++; if (dif.o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid_drop: got %b expected 0", dif.o_valid); end
    n_tests++; if (dif.o_busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %b expected 1", dif.o_busy); end
    wait_result(got, lat, q, f, e);
    ex = sb.pop_front();
    n_tests++; if (lat !== ex.lat) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected %0d", lat, ex.lat); end
    n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL b2b_second_quot: got %h expected %h", q, ex.q); end
    n_tests++; if (e !== ex.e) begin n_fail++; $display("FAIL b2b_second_err: got %b expected %b", e, ex.e); end
  endtask

  task automatic test_reset_mid();
    exp_t ex; logic got; int lat; logic [31:0] q; logic [3:0] f; logic e; int nvalid = 0;
    ex.q = 32'd100; ex.f = 4'b0000; ex.e = 1'b0; ex.lat = 33;
    issue(32'd1000, 32'd10, 1'b0, ex);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb.pop_front());
    n_tests++; if (dif.o_busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", dif.o_busy); end
    n_tests++; if (dif.o_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", dif.o_valid); end
    n_tests++; if (dif.o_err !== 1'b0) begin n_fail++; $display("FAIL rmid_err: got %b expected 0", dif.o_err); end
    n_tests++; if (dif.o_quotient !== 32'd0) begin n_fail++; $display("FAIL rmid_quot: got %h expected 0", dif.o_quotient); end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (dif.o_valid) nvalid++;
    end
    n_tests++; if (nvalid !== 0) begin n_fail++; $display("FAIL rmid_stray_valid: got %0d expected 0", nvalid); end
    ex.q = 32'd3; ex.f = 4'b0000; ex.e = 1'b0; ex.lat = 33;
    issue(32'd9, 32'd3, 1'b0, ex);
    wait_result(got, lat, q, f, e);
    ex = sb.pop_front();
    n_tests++; if (lat !== ex.lat) begin n_fail++; $display("FAIL rmid_fresh_latency: got %0d expected %0d", lat, ex.lat); end
    n_tests++; if (q !== ex.q) begin n_fail++; $display("FAIL rmid_fresh_quot: got %h expected %h", q, ex.q); end
    n_tests++; if (f !== ex.f) begin n_fail++; $display("FAIL rmid_fresh_flags: got %b expected %b", f, ex.f); end
  endtask

  initial begin
    test_reset();
    test_divide();
    test_div_zero();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
